// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core/debug memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;

  localparam logic ARB_ID_CORE = 1'b0;
  localparam logic ARB_ID_DBG  = 1'b1;

  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way winner select for the memory port arbiter.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester not served last; otherwise dbg wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic core_req,
  input  logic dbg_req,
  input  logic last_id,
  output logic grant_valid,
  output logic grant_id
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_id;
  assign unused_last_id = last_id;
`endif

  always_comb begin
    grant_valid = core_req | dbg_req;
    grant_id    = ARB_ID_CORE;
    if (core_req && dbg_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_id = ~last_id;
`else
      // Loader/halt traffic must never be starved by a busy core.
      grant_id = ARB_ID_DBG;
`endif
    end else if (dbg_req) begin
      grant_id = ARB_ID_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified instruction/data memory between the multicycle core and the debug/loader port.
// Tie policy set by MEM_ARB_ROUND_ROBIN_EN (round robin) or, when undefined, fixed dbg priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_done,
  output logic [DW-1:0] core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          arb_busy
);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             last_id;
  logic             id_p0;
  logic             grant_valid, grant_id;
  logic             accept, rd_cap;
  logic             mem_en_nxt, core_done_nxt, dbg_done_nxt;

  mem_arb_pick u_pick (
    .core_req    (core_req),
    .dbg_req     (dbg_req),
    .last_id     (last_id),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    rd_cap        = 1'b0;
    mem_en_nxt    = 1'b0;
    core_done_nxt = 1'b0;
    dbg_done_nxt  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (grant_valid) begin
          accept     = 1'b1;
          mem_en_nxt = 1'b1;
          state_nxt  = ARB_ACCESS;
        end
      end
      ARB_ACCESS: state_nxt = (MEM_LAT == 1) ? ARB_RESP : ARB_WAIT;
      // Counter reaching zero on this decrement ends the wait.
      ARB_WAIT: if (wait_cnt == CNT_W'(1)) state_nxt = ARB_RESP;
      ARB_RESP: begin
        state_nxt     = ARB_IDLE;
        rd_cap        = ~mem_we;
        core_done_nxt = (id_p0 == ARB_ID_CORE);
        dbg_done_nxt  = (id_p0 == ARB_ID_DBG);
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Request latch stage: everything the memory sees comes from the copy taken at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      last_id    <= ARB_ID_CORE;
      id_p0      <= ARB_ID_CORE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_done  <= 1'b0;
      dbg_done   <= 1'b0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
      arb_busy   <= 1'b0;
    end else begin
      mem_en    <= mem_en_nxt;
      core_done <= core_done_nxt;
      dbg_done  <= dbg_done_nxt;
      arb_busy  <= (state_nxt != ARB_IDLE);
      if (accept) begin
        id_p0     <= grant_id;
        last_id   <= grant_id;
        mem_we    <= grant_id ? dbg_we    : core_we;
        mem_addr  <= grant_id ? dbg_addr  : core_addr;
        mem_wdata <= grant_id ? dbg_wdata : core_wdata;
      end
      if (state == ARB_ACCESS)    wait_cnt <= CNT_W'(MEM_LAT - 1);
      else if (state == ARB_WAIT) wait_cnt <= wait_cnt - CNT_W'(1);
      if (rd_cap) begin
        if (id_p0 == ARB_ID_CORE) core_rdata <= mem_rdata;
        else                      dbg_rdata  <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: two arbiters (MEM_LAT 1 and 4) checked against a transaction-timeline model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NI   = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 4;
  localparam int NCYC = 5000;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic init_mem = 1'b1;

  logic          core_req   [NI];
  logic          core_we    [NI];
  logic [AW-1:0] core_addr  [NI];
  logic [DW-1:0] core_wdata [NI];
  logic          core_done  [NI];
  logic [DW-1:0] core_rdata [NI];
  logic          dbg_req    [NI];
  logic          dbg_we     [NI];
  logic [AW-1:0] dbg_addr   [NI];
  logic [DW-1:0] dbg_wdata  [NI];
  logic          dbg_done   [NI];
  logic [DW-1:0] dbg_rdata  [NI];
  logic          mem_en     [NI];
  logic          mem_we     [NI];
  logic [AW-1:0] mem_addr   [NI];
  logic [DW-1:0] mem_wdata  [NI];
  logic          arb_busy   [NI];

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [DW-1:0] init_word(input int i, input int k);
    return 32'hA500_005A | (32'(i) << 16) | (32'(k) << 8);
  endfunction

  // DUTs plus a memory whose read data is only valid MEM_LAT cycles after the strobe.
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LATG = (g == 0) ? LAT0 : LAT1;
    logic [DW-1:0] pmem    [16];
    logic [DW-1:0] rd_pipe [16];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LATG)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .core_req   (core_req[g]),
      .core_we    (core_we[g]),
      .core_addr  (core_addr[g]),
      .core_wdata (core_wdata[g]),
      .core_done  (core_done[g]),
      .core_rdata (core_rdata[g]),
      .dbg_req    (dbg_req[g]),
      .dbg_we     (dbg_we[g]),
      .dbg_addr   (dbg_addr[g]),
      .dbg_wdata  (dbg_wdata[g]),
      .dbg_done   (dbg_done[g]),
      .dbg_rdata  (dbg_rdata[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (rd_pipe[LATG-1]),
      .arb_busy   (arb_busy[g])
    );

    always @(posedge clk) begin
      for (int k = 15; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
      rd_pipe[0] <= (mem_en[g] && !mem_we[g]) ? pmem[mem_addr[g][5:2]] : $urandom;
      if (init_mem) begin
        for (int k = 0; k < 16; k++) pmem[k] <= init_word(g, k);
      end else if (mem_en[g] && mem_we[g]) begin
        pmem[mem_addr[g][5:2]] <= mem_wdata[g];
      end
    end
  end

  // Reference model state: at most one transaction in flight per arbiter.
  int            edge_n = 0;
  logic          act      [NI];
  logic          act_id   [NI];
  logic          act_we   [NI];
  logic [AW-1:0] act_addr [NI];
  logic [DW-1:0] act_wdata[NI];
  logic [DW-1:0] act_rd   [NI];
  int            act_s    [NI];
  logic          last_srv [NI];
  logic [DW-1:0] mmem     [NI][16];
  logic          e_cdone  [NI];
  logic          e_ddone  [NI];
  logic          e_en     [NI];
  logic          e_busy   [NI];
  logic [DW-1:0] e_crd    [NI];
  logic [DW-1:0] e_drd    [NI];
  int            n_done   [NI];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (edge %0d)", tag, obs, exp, edge_n);
  endtask

  // Advance the model across one rising edge using the inputs the DUT just sampled.
  task automatic model_step();
    logic       w;
    logic [3:0] idx;
    edge_n++;
    for (int i = 0; i < NI; i++) begin
      if (init_mem)
        for (int k = 0; k < 16; k++) mmem[i][k] = init_word(i, k);
      e_cdone[i] = 1'b0;
      e_ddone[i] = 1'b0;
      if (rst) begin
        act[i]      = 1'b0;
        last_srv[i] = ARB_ID_CORE;
        e_crd[i]    = '0;
        e_drd[i]    = '0;
      end else if (act[i] && edge_n == act_s[i] + lat_of(i) + 1) begin
        if (act_id[i] == ARB_ID_DBG) begin
          e_ddone[i] = 1'b1;
          if (!act_we[i]) e_drd[i] = act_rd[i];
        end else begin
          e_cdone[i] = 1'b1;
          if (!act_we[i]) e_crd[i] = act_rd[i];
        end
        act[i] = 1'b0;
      end else if (!act[i] && (core_req[i] || dbg_req[i])) begin
        if (core_req[i] && dbg_req[i]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          w = (last_srv[i] == ARB_ID_CORE) ? ARB_ID_DBG : ARB_ID_CORE;
`else
          w = ARB_ID_DBG;
`endif
        end else begin
          w = dbg_req[i] ? ARB_ID_DBG : ARB_ID_CORE;
        end
        act[i]       = 1'b1;
        act_s[i]     = edge_n;
        act_id[i]    = w;
        last_srv[i]  = w;
        act_we[i]    = w ? dbg_we[i]    : core_we[i];
        act_addr[i]  = w ? dbg_addr[i]  : core_addr[i];
        act_wdata[i] = w ? dbg_wdata[i] : core_wdata[i];
        idx = act_addr[i][5:2];
        if (act_we[i]) mmem[i][idx] = act_wdata[i];
        else           act_rd[i]    = mmem[i][idx];
      end
      e_en[i]   = act[i] && (edge_n == act_s[i]);
      e_busy[i] = act[i] && (edge_n <= act_s[i] + lat_of(i));
    end
  endtask

  task automatic compare();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.core_done", i),  32'(core_done[i]), 32'(e_cdone[i]));
      chk($sformatf("u%0d.dbg_done", i),   32'(dbg_done[i]),  32'(e_ddone[i]));
      chk($sformatf("u%0d.core_rdata", i), core_rdata[i],     e_crd[i]);
      chk($sformatf("u%0d.dbg_rdata", i),  dbg_rdata[i],      e_drd[i]);
      chk($sformatf("u%0d.mem_en", i),     32'(mem_en[i]),    32'(e_en[i]));
      chk($sformatf("u%0d.arb_busy", i),   32'(arb_busy[i]),  32'(e_busy[i]));
      if (e_busy[i]) begin
        chk($sformatf("u%0d.mem_addr", i),  mem_addr[i],      act_addr[i]);
        chk($sformatf("u%0d.mem_we", i),    32'(mem_we[i]),   32'(act_we[i]));
        chk($sformatf("u%0d.mem_wdata", i), mem_wdata[i],     act_wdata[i]);
      end else if (rst) begin
        chk($sformatf("u%0d.rst_mem_addr", i),  mem_addr[i],    32'd0);
        chk($sformatf("u%0d.rst_mem_we", i),    32'(mem_we[i]), 32'd0);
        chk($sformatf("u%0d.rst_mem_wdata", i), mem_wdata[i],   32'd0);
      end
      if (core_done[i] || dbg_done[i]) n_done[i]++;
    end
  endtask

  // Requesters hold req until done, then either drop it or immediately re-request.
  task automatic drive(input int cyc);
    if (cyc < 3) begin
      rst = 1'b1;
    end else if (cyc == 3) begin
      rst      = 1'b0;
      init_mem = 1'b0;
    end else begin
      rst = ($urandom_range(0, 249) == 0);
    end
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        core_req[i] = 1'b0;
        dbg_req[i]  = 1'b0;
      end else begin
        if (cyc == 3 ||
            (core_req[i] && core_done[i] && $urandom_range(0, 3) == 0) ||
            (!core_req[i] && $urandom_range(0, 2) == 0) ||
            (core_req[i] && !core_done[i] && $urandom_range(0, 1) == 0)) begin
          core_req[i]   = 1'b1;
          core_we[i]    = 1'($urandom_range(0, 1));
          core_addr[i]  = $urandom;
          core_wdata[i] = $urandom;
        end else if (core_req[i] && core_done[i]) begin
          core_req[i] = 1'b0;
        end
        if (cyc == 3 ||
            (dbg_req[i] && dbg_done[i] && $urandom_range(0, 3) == 0) ||
            (!dbg_req[i] && $urandom_range(0, 2) == 0) ||
            (dbg_req[i] && !dbg_done[i] && $urandom_range(0, 1) == 0)) begin
          dbg_req[i]   = 1'b1;
          dbg_we[i]    = 1'($urandom_range(0, 1));
          dbg_addr[i]  = $urandom;
          dbg_wdata[i] = $urandom;
        end else if (dbg_req[i] && dbg_done[i]) begin
          dbg_req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      core_req[i]   = 1'b0;
      core_we[i]    = 1'b0;
      core_addr[i]  = '0;
      core_wdata[i] = '0;
      dbg_req[i]    = 1'b0;
      dbg_we[i]     = 1'b0;
      dbg_addr[i]   = '0;
      dbg_wdata[i]  = '0;
      act[i]        = 1'b0;
      n_done[i]     = 0;
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      drive(cyc);
    end
    for (int i = 0; i < NI; i++)
      chk($sformatf("u%0d.activity", i), 32'(n_done[i] > 100), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
